// File: rtl/stop_watch_ctrl_if.sv
// Button inputs and counter-control outputs of the stopwatch front end.
// master = board/pin side, slave = stop_watch_ctrl.
interface stop_watch_ctrl_if;
    logic btn_ss;
    logic btn_clr;
    logic go;
    logic clr;
    logic ss_db;
    logic clr_db;

    modport master (
        output btn_ss, btn_clr,
        input  go, clr, ss_db, clr_db
    );

    modport slave (
        input  btn_ss, btn_clr,
        output go, clr, ss_db, clr_db
    );
endinterface

// File: rtl/stop_watch_ctrl.sv
// Stopwatch button front end: sync, debounce, press-edge detect,
// and go/clr generation for the three-digit counter.
module stop_watch_ctrl #(
    parameter int N = 19
) (
    input logic             clk,
    input logic             reset,
    stop_watch_ctrl_if.slave io
);
    typedef enum logic [1:0] {
        ZERO,
        WAIT1,
        ONE,
        WAIT0
    } db_state_e;

    localparam logic [N-1:0] M    = '1;
    localparam logic [N-1:0] STEP = N'(1);

    // index 0 = start/stop, index 1 = clear
    logic [1:0]  s1_q, s2_q;
    db_state_e   st_q   [2];
    db_state_e   st_d   [2];
    logic [N-1:0] cnt_q [2];
    logic [N-1:0] cnt_d [2];
    logic [1:0]  db_q, db_d;
    logic [1:0]  rise;
    logic        go_q, go_d;
    logic        clr_q, clr_d;

    always_comb begin
        rise = 2'b00;
        db_d = 2'b00;
        for (int i = 0; i < 2; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
            unique case (st_q[i])
                ZERO: begin
                    if (s2_q[i]) begin
                        cnt_d[i] = M;
                        st_d[i]  = WAIT1;
                    end
                end
                WAIT1: begin
                    if (!s2_q[i]) begin
                        st_d[i] = ZERO;
                    end else if (cnt_q[i] != '0) begin
                        cnt_d[i] = cnt_q[i] - STEP;
                    end else begin
                        st_d[i] = ONE;
                        rise[i] = 1'b1;
                    end
                end
                ONE: begin
                    if (!s2_q[i]) begin
                        cnt_d[i] = M;
                        st_d[i]  = WAIT0;
                    end
                end
                WAIT0: begin
                    if (s2_q[i]) begin
                        st_d[i] = ONE;
                    end else if (cnt_q[i] != '0) begin
                        cnt_d[i] = cnt_q[i] - STEP;
                    end else begin
                        st_d[i] = ZERO;
                    end
                end
            endcase
            db_d[i] = (st_d[i] == ONE) || (st_d[i] == WAIT0);
        end
    end

    // A clear press also stops, and beats a same-edge start/stop press.
    always_comb begin
        clr_d = rise[1];
        go_d  = go_q;
        if (rise[1]) begin
            go_d = 1'b0;
        end else if (rise[0]) begin
            go_d = ~go_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q  <= 2'b00;
            s2_q  <= 2'b00;
            db_q  <= 2'b00;
            go_q  <= 1'b0;
            clr_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                st_q[i]  <= ZERO;
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q  <= {io.btn_clr, io.btn_ss};
            s2_q  <= s1_q;
            db_q  <= db_d;
            go_q  <= go_d;
            clr_q <= clr_d;
            for (int i = 0; i < 2; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign io.go     = go_q;
    assign io.clr    = clr_q;
    assign io.ss_db  = db_q[0];
    assign io.clr_db = db_q[1];
endmodule

// File: tb/tb_stop_watch_ctrl.sv
// Bench for stop_watch_ctrl (N=3): directed plan plus random presses,
// checked every cycle against a run-length debounce model.
module tb_stop_watch_ctrl;
    localparam int N   = 3;
    localparam int WIN = 1 << N;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    stop_watch_ctrl_if bus ();

    stop_watch_ctrl #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int clr_pulses = 0;

    // model: two-stage delay, then a level commits after WIN+1
    // consecutive samples opposite to the current debounced level
    bit m_s1 [2];
    bit m_s2 [2];
    bit m_db [2];
    int m_run [2];
    bit m_go;
    bit m_clr;

    function automatic void model_clear();
        for (int i = 0; i < 2; i++) begin
            m_s1[i]  = 1'b0;
            m_s2[i]  = 1'b0;
            m_db[i]  = 1'b0;
            m_run[i] = 0;
        end
        m_go  = 1'b0;
        m_clr = 1'b0;
    endfunction

    function automatic void model_edge();
        bit btn [2];
        bit rs  [2];
        bit seen;
        if (reset) begin
            model_clear();
            return;
        end
        btn[0] = bus.btn_ss;
        btn[1] = bus.btn_clr;
        for (int i = 0; i < 2; i++) begin
            seen    = m_s2[i];
            m_s2[i] = m_s1[i];
            m_s1[i] = btn[i];
            rs[i]   = 1'b0;
            if (seen != m_db[i]) begin
                m_run[i]++;
                if (m_run[i] == WIN + 1) begin
                    m_db[i]  = seen;
                    m_run[i] = 0;
                    rs[i]    = seen;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_clr = rs[1];
        if (rs[1]) m_go = 1'b0;
        else if (rs[0]) m_go = !m_go;
    endfunction

    task automatic cmp(input string tag, input logic obs,
                       input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic cmp_int(input string tag, input int obs,
                           input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic check(input string tag);
        cmp({tag, "_go"}, bus.go, m_go);
        cmp({tag, "_clr"}, bus.clr, m_clr);
        cmp({tag, "_ssdb"}, bus.ss_db, m_db[0]);
        cmp({tag, "_clrdb"}, bus.clr_db, m_db[1]);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check(tag);
        if (bus.clr === 1'b1) clr_pulses++;
    endtask

    task automatic hold(input logic ss, input logic c,
                        input int n, input string tag);
        bus.btn_ss  = ss;
        bus.btn_clr = c;
        repeat (n) step(tag);
    endtask

    task automatic async_reset(input string tag);
        #3 reset = 1'b1;
        model_clear();
        #1;
        check(tag);
        repeat (2) step({tag, "_held"});
        reset = 1'b0;
    endtask

    initial begin
        int n;
        int first;
        int p0;
        bus.btn_ss  = 1'b0;
        bus.btn_clr = 1'b0;
        model_clear();
        #2 reset = 1'b1;
        #1;
        check("reset");
        repeat (2) step("reset_held");
        reset = 1'b0;
        hold(0, 0, 3, "idle");

        // bounce rejected
        hold(1, 0, 5, "bounce");
        hold(0, 0, 2, "bounce");
        hold(1, 0, 5, "bounce");
        hold(0, 0, 12, "bounce");
        cmp("bounce_go", bus.go, 1'b0);
        cmp("bounce_db", bus.ss_db, 1'b0);

        // clean start
        p0 = clr_pulses;
        bus.btn_ss = 1'b1;
        first = -1;
        for (int i = 1; i <= 20; i++) begin
            step("start");
            if (first < 0 && bus.ss_db === 1'b1) first = i;
        end
        cmp_int("start_lat", first, 11);
        cmp("start_go", bus.go, 1'b1);
        bus.btn_ss = 1'b0;
        first = -1;
        for (int i = 1; i <= 14; i++) begin
            step("release");
            if (first < 0 && bus.ss_db === 1'b0) first = i;
        end
        cmp_int("release_lat", first, 11);
        cmp("go_held", bus.go, 1'b1);
        cmp_int("start_noclr", clr_pulses, p0);

        // stop
        bus.btn_ss = 1'b1;
        first = -1;
        for (int i = 1; i <= 14; i++) begin
            step("stop");
            if (first < 0 && bus.go === 1'b0) first = i;
        end
        cmp_int("stop_lat", first, 11);
        hold(0, 0, 14, "stop_rel");

        // run again, then clear while running
        hold(1, 0, 14, "rerun");
        hold(0, 0, 14, "rerun_rel");
        cmp("rerun_go", bus.go, 1'b1);
        p0 = clr_pulses;
        bus.btn_clr = 1'b1;
        first = -1;
        for (int i = 1; i <= 20; i++) begin
            step("clear");
            if (first < 0 && bus.clr === 1'b1) begin
                first = i;
                cmp("clear_go", bus.go, 1'b0);
            end
        end
        cmp_int("clear_lat", first, 11);
        hold(0, 1, 10, "clear_hold");
        cmp_int("clear_once", clr_pulses - p0, 1);
        hold(0, 0, 14, "clear_rel");

        // simultaneous presses: clear wins
        p0 = clr_pulses;
        hold(1, 1, 12, "both");
        cmp_int("both_pulse", clr_pulses - p0, 1);
        cmp("both_go", bus.go, 1'b0);
        hold(0, 0, 14, "both_rel");

        // reset mid-debounce with button held
        bus.btn_ss = 1'b1;
        repeat (5) step("prerst");
        async_reset("rst_mid");
        n = 0;
        while (bus.go !== 1'b1 && n < 30) begin
            n++;
            step("post_rst");
        end
        cmp_int("post_rst_lat", n, 11);
        hold(0, 0, 14, "post_rst_rel");

        // random presses and holds
        repeat (40) begin
            bus.btn_ss  = 1'($urandom_range(0, 1));
            bus.btn_clr = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(1, 14)) step("rand");
        end

        // reset while running clears go at once
        hold(0, 0, 14, "fin_rel");
        hold(1, 0, 14, "fin_run");
        async_reset("rst_run");
        hold(0, 0, 3, "fin_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
